// File: rtl/bf_weight_loader.sv
// SPI-fed beamformer weight register file with a shadow bank and an atomic commit
// into the active bank that drives the delta-sigma modulators.
module bf_weight_loader #(
  parameter int unsigned N_CH        = 8,
  parameter int unsigned W_BITS      = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     sclk,
  input  logic                     mosi,
  input  logic                     ss,
  output logic [N_CH*W_BITS-1:0]   w_cos_1,
  output logic [N_CH*W_BITS-1:0]   w_sin_1,
  output logic [N_CH*W_BITS-1:0]   w_cos_2,
  output logic [N_CH*W_BITS-1:0]   w_sin_2,
  output logic                     weights_valid,
  output logic                     update,
  output logic                     frame_err
);

  localparam int unsigned FRAME_BITS = 32;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned N_SETS     = 4;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  localparam logic [3:0] CMD_WRITE  = 4'h1;
  localparam logic [3:0] CMD_COMMIT = 4'h2;
  localparam logic [3:0] CMD_CLEAR  = 4'h3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
  logic sclk_s, mosi_s, ss_s;
  logic sclk_d, ss_d;
  logic sclk_rise, ss_rise, ss_fall;

  logic [FRAME_BITS-1:0] shreg_q;
  logic [CNT_W-1:0]      bit_cnt_q;

  logic [N_SETS-1:0][N_CH-1:0][W_BITS-1:0] shadow_q;
  logic [N_SETS-1:0][N_CH-1:0][W_BITS-1:0] active_q;

  logic shift_clr_c, shift_en_c, exec_c, commit_c, err_c;

  logic [3:0]        frame_cmd;
  logic [1:0]        frame_set;
  logic [2:0]        frame_ch;
  logic [W_BITS-1:0] frame_value;
  logic              unused_frame_bits;

  // Two-flop (or deeper) synchronizers; idle levels are SCLK low, SS high
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign ss_rise   = ss_s & ~ss_d;
  assign ss_fall   = ~ss_s & ss_d;

  assign frame_cmd         = shreg_q[31:28];
  assign frame_set         = shreg_q[27:26];
  assign frame_ch          = shreg_q[25:23];
  assign frame_value       = shreg_q[W_BITS-1:0];
  assign unused_frame_bits = ^shreg_q[22:W_BITS];

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (ss_fall) state_d = ST_SHIFT;
      ST_SHIFT: if (ss_rise) state_d = ST_CHECK;
      ST_CHECK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: datapath strobes
  always_comb begin
    shift_clr_c = 1'b0;
    shift_en_c  = 1'b0;
    exec_c      = 1'b0;
    commit_c    = 1'b0;
    err_c       = 1'b0;
    unique case (state_q)
      ST_IDLE:  shift_clr_c = ss_fall;
      ST_SHIFT: shift_en_c  = sclk_rise;
      ST_CHECK: begin
        if (bit_cnt_q == CNT_FULL) begin
          exec_c   = 1'b1;
          commit_c = (frame_cmd == CMD_COMMIT);
        end else begin
          err_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Frame shift register and saturating bit counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else if (shift_clr_c) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else if (shift_en_c) begin
      shreg_q <= {shreg_q[FRAME_BITS-2:0], mosi_s};
      if (bit_cnt_q != CNT_SAT) bit_cnt_q <= bit_cnt_q + CNT_W'(1);
    end
  end

  // Shadow bank: single-entry write or full clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shadow_q <= '0;
    end else if (exec_c) begin
      if (frame_cmd == CMD_WRITE) begin
        for (int unsigned s = 0; s < N_SETS; s++) begin
          for (int unsigned k = 0; k < N_CH; k++) begin
            if (frame_set == 2'(s) && frame_ch == 3'(k)) shadow_q[s][k] <= frame_value;
          end
        end
      end else if (frame_cmd == CMD_CLEAR) begin
        shadow_q <= '0;
      end
    end
  end

  // Active bank loads all entries on one edge, with status pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active_q      <= '0;
      weights_valid <= 1'b0;
      update        <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      update    <= commit_c;
      frame_err <= err_c;
      if (commit_c) begin
        active_q      <= shadow_q;
        weights_valid <= 1'b1;
      end
    end
  end

  assign w_cos_1 = active_q[0];
  assign w_sin_1 = active_q[1];
  assign w_cos_2 = active_q[2];
  assign w_sin_2 = active_q[3];

endmodule

// File: tb/tb_bf_weight_loader.sv
// Directed bench for bf_weight_loader: table of SPI frames with expected active
// banks and pulse counts, plus reset and mid-frame corner sequences.
module tb_bf_weight_loader;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk  = 1'b0;
  logic        mosi  = 1'b0;
  logic        ss    = 1'b1;
  logic [39:0] w_cos_1, w_sin_1, w_cos_2, w_sin_2;
  logic        weights_valid, update, frame_err;

  int total = 0;
  int bad   = 0;
  int upd_cnt = 0, err_cnt = 0, both_cnt = 0, glitch_cnt = 0;
  logic [159:0] prev_bus = '0;

  bf_weight_loader dut (
    .clock         (clock),
    .reset         (rst_n),
    .sclk          (sclk),
    .mosi          (mosi),
    .ss            (ss),
    .w_cos_1       (w_cos_1),
    .w_sin_1       (w_sin_1),
    .w_cos_2       (w_cos_2),
    .w_sin_2       (w_sin_2),
    .weights_valid (weights_valid),
    .update        (update),
    .frame_err     (frame_err)
  );

  always #5 clock = ~clock;

  // Pulse counting and bus-stability monitor, sampled on the falling edge
  always @(negedge clock) begin
    if (rst_n) begin
      if (update) upd_cnt++;
      if (frame_err) err_cnt++;
      if (update && frame_err) both_cnt++;
      if ({w_cos_1, w_sin_1, w_cos_2, w_sin_2} != prev_bus && !update) glitch_cnt++;
    end
    prev_bus = {w_cos_1, w_sin_1, w_cos_2, w_sin_2};
  end

  typedef struct {
    string       name;
    logic [31:0] frame;
    int          nbits;
    logic [39:0] cos1, sin1, cos2, sin2;
    logic        valid;
    int          upd;
    int          err;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input string name, input logic [31:0] frame, input int nbits,
                              input logic [39:0] c1, input logic [39:0] s1,
                              input logic [39:0] c2, input logic [39:0] s2,
                              input logic v, input int u, input int e);
    vec_t r;
    r.name = name; r.frame = frame; r.nbits = nbits;
    r.cos1 = c1; r.sin1 = s1; r.cos2 = c2; r.sin2 = s2;
    r.valid = v; r.upd = u; r.err = e;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
  endtask

  // Drives SS low and clocks out nbits MSB-first; bits past 32 are zero
  task automatic shift_bits(input logic [31:0] data, input int nbits);
    ss = 1'b0;
    wait_clk(4);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 32) ? data[31-i] : 1'b0;
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
  endtask

  task automatic send(input logic [31:0] data, input int nbits);
    shift_bits(data, nbits);
    wait_clk(4);
    ss = 1'b1;
    wait_clk(12);
  endtask

  task automatic chk_buses(input string tag, input logic [39:0] c1, input logic [39:0] s1,
                           input logic [39:0] c2, input logic [39:0] s2);
    chk({tag, " cos1"}, 64'(w_cos_1), 64'(c1));
    chk({tag, " sin1"}, 64'(w_sin_1), 64'(s1));
    chk({tag, " cos2"}, 64'(w_cos_2), 64'(c2));
    chk({tag, " sin2"}, 64'(w_sin_2), 64'(s2));
  endtask

  localparam logic [39:0] C1  = 40'h00_0000_02A0;
  localparam logic [39:0] S2  = 40'h88_0000_0000;
  localparam logic [39:0] C2  = 40'h00_0000_0009;
  localparam logic [39:0] S1  = 40'h00_000F_8000;
  localparam logic [39:0] Z   = 40'h0;

  initial begin
    int u0, e0;

    vecs[0]  = mk("write_c1ch1",  32'h10800015, 32, Z,  Z,  Z,  Z,  1'b0, 0, 0);
    vecs[1]  = mk("commit1",      32'h20000000, 32, C1, Z,  Z,  Z,  1'b1, 1, 0);
    vecs[2]  = mk("short31",      32'h10800015, 31, C1, Z,  Z,  Z,  1'b1, 0, 1);
    vecs[3]  = mk("commit_short", 32'h20000000, 32, C1, Z,  Z,  Z,  1'b1, 1, 0);
    vecs[4]  = mk("write_s2ch7",  32'h1F800011, 32, C1, Z,  Z,  Z,  1'b1, 0, 0);
    vecs[5]  = mk("commit_s2",    32'h20000000, 32, C1, Z,  Z,  S2, 1'b1, 1, 0);
    vecs[6]  = mk("write_c2ch0",  32'h18000009, 32, C1, Z,  Z,  S2, 1'b1, 0, 0);
    vecs[7]  = mk("write_s1ch3",  32'h1580001F, 32, C1, Z,  Z,  S2, 1'b1, 0, 0);
    vecs[8]  = mk("unknown_cmd",  32'h50000000, 32, C1, Z,  Z,  S2, 1'b1, 0, 0);
    vecs[9]  = mk("commit_all",   32'h20000000, 32, C1, S1, C2, S2, 1'b1, 1, 0);
    vecs[10] = mk("clear",        32'h30000000, 32, C1, S1, C2, S2, 1'b1, 0, 0);
    vecs[11] = mk("commit_clear", 32'h20000000, 32, Z,  Z,  Z,  Z,  1'b1, 1, 0);
    vecs[12] = mk("long33",       32'h10800015, 33, Z,  Z,  Z,  Z,  1'b1, 0, 1);
    vecs[13] = mk("commit_long",  32'h20000000, 32, Z,  Z,  Z,  Z,  1'b1, 1, 0);
    vecs[14] = mk("write_again",  32'h10800015, 32, Z,  Z,  Z,  Z,  1'b1, 0, 0);
    vecs[15] = mk("commit_again", 32'h20000000, 32, C1, Z,  Z,  Z,  1'b1, 1, 0);

    // Reset held while SCLK toggles
    for (int i = 0; i < 10; i++) begin
      sclk = ~sclk;
      wait_clk(1);
    end
    sclk = 1'b0;
    @(negedge clock);
    chk_buses("reset", Z, Z, Z, Z);
    chk("reset valid", 64'(weights_valid), 64'd0);
    chk("reset update", 64'(update), 64'd0);
    chk("reset frame_err", 64'(frame_err), 64'd0);
    rst_n = 1'b1;
    wait_clk(6);
    chk("reset pulses", 64'(upd_cnt + err_cnt), 64'd0);

    for (int i = 0; i < 16; i++) begin
      u0 = upd_cnt;
      e0 = err_cnt;
      send(vecs[i].frame, vecs[i].nbits);
      @(negedge clock);
      chk_buses(vecs[i].name, vecs[i].cos1, vecs[i].sin1, vecs[i].cos2, vecs[i].sin2);
      chk({vecs[i].name, " valid"}, 64'(weights_valid), 64'(vecs[i].valid));
      chk({vecs[i].name, " update pulses"}, 64'(upd_cnt - u0), 64'(vecs[i].upd));
      chk({vecs[i].name, " err pulses"}, 64'(err_cnt - e0), 64'(vecs[i].err));
    end

    // Reset after 16 bits of a WRITE, with a committed nonzero bank in place
    shift_bits(32'h1F800011, 16);
    rst_n = 1'b0;
    ss    = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    wait_clk(3);
    @(negedge clock);
    chk_buses("midreset", Z, Z, Z, Z);
    chk("midreset valid", 64'(weights_valid), 64'd0);
    chk("midreset pulses", 64'({update, frame_err}), 64'd0);
    wait_clk(7);
    rst_n = 1'b1;
    wait_clk(6);
    u0 = upd_cnt;
    e0 = err_cnt;
    send(32'h10800015, 32);
    send(32'h20000000, 32);
    @(negedge clock);
    chk_buses("post_reset", C1, Z, Z, Z);
    chk("post_reset valid", 64'(weights_valid), 64'd1);
    chk("post_reset update pulses", 64'(upd_cnt - u0), 64'd1);
    chk("post_reset err pulses", 64'(err_cnt - e0), 64'd0);

    // SS already low when reset releases: the partial frame is rejected
    rst_n = 1'b0;
    ss    = 1'b0;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(6);
    u0 = upd_cnt;
    e0 = err_cnt;
    shift_bits(32'h20000000, 10);
    wait_clk(4);
    ss = 1'b1;
    wait_clk(12);
    @(negedge clock);
    chk("ss_low_rel err pulses", 64'(err_cnt - e0), 64'd1);
    chk("ss_low_rel update pulses", 64'(upd_cnt - u0), 64'd0);
    chk("ss_low_rel valid", 64'(weights_valid), 64'd0);
    chk_buses("ss_low_rel", Z, Z, Z, Z);

    chk("update and frame_err together", 64'(both_cnt), 64'd0);
    chk("bus change without update", 64'(glitch_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bf_weight_loader.md
# bf_weight_loader

SPI-fed weight register file sitting directly upstream of the beamformer top. Receives 32-bit command frames on SCLK/MOSI/SS, which are asynchronous to CLOCK, and synchronizes them into the CLOCK domain. Writes 5-bit two's-complement cos/sin weights for 8 channels and 2 weight sets into a shadow bank. A commit command copies the shadow bank into the active bank atomically, so the delta-sigma modulators never see a half-updated weight set.

## Interface
- N_CH, 8, number of channels
- W_BITS, 5, weight width, two's complement
- SYNC_STAGES, 2, flip-flop depth of the SCLK/MOSI/SS synchronizers (minimum 2)

- CLOCK  in  1  system clock; all state is on the rising edge
- RESET  in  1  asynchronous, active-low reset
- SCLK  in  1  SPI clock, mode 0; MOSI is sampled on SCLK rising
- MOSI  in  1  serial data, MSB first
- SS  in  1  slave select, active low
- W_COS_1  out  N_CH*W_BITS  active set-1 cos weights; channel k at [W_BITS*k+W_BITS-1 : W_BITS*k]
- W_SIN_1  out  N_CH*W_BITS  active set-1 sin weights, same packing
- W_COS_2  out  N_CH*W_BITS  active set-2 cos weights, same packing
- W_SIN_2  out  N_CH*W_BITS  active set-2 sin weights, same packing
- WEIGHTS_VALID  out  1  high after the first commit since reset
- UPDATE  out  1  one-cycle pulse when the active bank is loaded
- FRAME_ERR  out  1  one-cycle pulse when a frame is rejected

## Operation
- Synchronizers: SCLK, MOSI and SS each pass through SYNC_STAGES flops. Reset values are SCLK=0, MOSI=0, SS=1. Edge detection is done on the synchronized outputs.
- Frame format, bit 31 first:
  - [31:28] CMD
  - [27:26] SET: 0=COS_1, 1=SIN_1, 2=COS_2, 3=SIN_2
  - [25:23] CH
  - [22:5] ignored
  - [4:0] VALUE
- Commands:
  - CMD 4'h1 WRITE: shadow[SET][CH] <= VALUE.
  - CMD 4'h2 COMMIT: active <= shadow (all 32 entries), UPDATE pulses, WEIGHTS_VALID <= 1.
  - CMD 4'h3 CLEAR: all shadow entries <= 0; the active bank is untouched.
  - Any other CMD: the frame is accepted and has no effect. FRAME_ERR does not pulse.
- FSM:
  - IDLE: wait for a synchronized SS falling edge -> SHIFT. Bit count cleared, shift register cleared.
  - SHIFT: on each synchronized SCLK rising edge, shift MOSI into bit 0 and increment the bit count. The count saturates at 33. A synchronized SS rising edge -> CHECK.
  - CHECK (1 cycle): if count == 32, execute the command; otherwise FRAME_ERR. Always -> IDLE.
- SCLK edges while in IDLE are ignored.
- A frame with fewer than or more than 32 bits is rejected whole, with no shadow or active change.
- SS low at reset release: the synchronized SS falls, so the FSM enters SHIFT mid-frame. That frame ends with a wrong count -> FRAME_ERR. This is the required behaviour.
- RESET asserted at any time, including mid-frame:
  - shadow, active and all outputs go to 0;
  - WEIGHTS_VALID = 0;
  - FSM -> IDLE;
  - synchronizers go to their reset values.
- Reset values of all outputs: every weight bus 0, WEIGHTS_VALID 0, UPDATE 0, FRAME_ERR 0.

## Timing
- CLOCK frequency must be at least 4x SCLK, and SCLK high and low phases must each be at least SYNC_STAGES+1 CLOCK periods. SS must stay high for at least 4 CLOCK cycles between frames.
- Let cycle E be the first CLOCK edge at which the synchronized SS is seen high after a frame. Then:
  - FSM is in CHECK during cycle E+1;
  - the shadow write, CLEAR, or active load and register update occur at edge E+2;
  - UPDATE or FRAME_ERR is high for exactly the cycle following edge E+2.
- Active weight buses change only at a COMMIT edge. All 4×8 entries change on the same edge, with no intermediate values visible.
- UPDATE and FRAME_ERR are never high in the same cycle.

## Test plan
- Reset: hold RESET=0 for 10 cycles while toggling SCLK -> all weight buses 0, WEIGHTS_VALID=0, no pulses.
- Write then commit:
  - Send 0x10800015 (WRITE, COS_1, CH1, -11). W_COS_1 stays 0 and UPDATE stays 0.
  - Send 0x20000000. Expect W_COS_1[9:5]=5'b10101 with all other bits 0, UPDATE pulses exactly once, WEIGHTS_VALID=1.
- Short frame: send 31 bits of 0x10800015 -> one FRAME_ERR pulse; a following COMMIT leaves W_COS_1[9:5] unchanged.
- Last channel, set 2:
  - Send 0x1F800011 (WRITE, SIN_2, CH7, -15), then COMMIT.
  - Expect W_SIN_2[39:35]=5'b10001, and W_COS_1[9:5] still 5'b10101.
- Clear: send 0x30000000. Active values are unchanged until COMMIT; after COMMIT all buses are 0, UPDATE pulses, and WEIGHTS_VALID stays 1.
- Reset mid-frame: assert RESET after 16 bits of a WRITE.
  - All outputs return to 0.
  - After release, a full 0x10800015 + COMMIT sequence loads correctly with no FRAME_ERR.
